// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] DEF_NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              adel;
  } if_id_t;

  function automatic if_id_t make_bubble(input logic [INST_W-1:0] nop);
    if_id_t b;
    b.valid = 1'b0;
    b.pc    = '0;
    b.inst  = nop;
    b.adel  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, and an idle fetch (ce low) loads a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   stall,
  input  logic   ce,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= make_bubble(NOP_INST);
    end else if (flush) begin
      q <= make_bubble(NOP_INST);
    end else if (stall) begin
      q <= q;
    end else if (!ce) begin
      q <= make_bubble(NOP_INST);
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: program counter, instruction-memory enable and IF/ID capture.
// Define FETCH_ALIGN_CHECK_EN to flag unaligned redirect targets on id_adel.
module pc_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_ce,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0] inst_data,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              id_adel
`endif
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              ce_reg;
  logic              pc_advance;
  logic [ADDR_W-1:0] target_pc;
  if_id_t            fetch_word;
  if_id_t            id_q;

  assign target_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
  // Stall holds the PC outright, so a redirect waits until the stall clears.
  assign pc_advance = ce_reg && !stall;

  always_comb begin
    pc_next = pc_reg;
    if (pc_advance) begin
      pc_next = redirect_valid ? target_pc : pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
      ce_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      ce_reg <= 1'b1;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic              adel_reg;
  logic [ADDR_W-1:0] err_pc_reg;

  // The error travels with the masked PC and is consumed by the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adel_reg   <= 1'b0;
      err_pc_reg <= '0;
    end else if (pc_advance) begin
      adel_reg   <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      err_pc_reg <= redirect_pc;
    end
  end
`endif

  always_comb begin
    fetch_word.valid = 1'b1;
    fetch_word.pc    = pc_reg;
    fetch_word.inst  = inst_data;
    fetch_word.adel  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    if (adel_reg) begin
      fetch_word.pc   = err_pc_reg;
      fetch_word.inst = NOP_INST;
      fetch_word.adel = 1'b1;
    end
`endif
  end

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .stall(stall),
    .ce   (ce_reg),
    .d    (fetch_word),
    .q    (id_q)
  );

  assign inst_ce   = ce_reg;
  assign inst_addr = pc_reg;
  assign id_valid  = id_q.valid;
  assign id_pc     = id_q.pc;
  assign id_inst   = id_q.inst;

`ifdef FETCH_ALIGN_CHECK_EN
  assign id_adel = id_q.adel;
`else
  logic [1:0] unused_redirect_lo;
  logic       unused_adel;
  assign unused_redirect_lo = redirect_pc[1:0];
  assign unused_adel        = id_q.adel;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: table of per-edge vectors plus hand-written reset sequences.
module tb_pc_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        id_adel;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0000f025;
    else if (a == 32'h4) return 32'h241d1000;
    else                 return 32'h3c00_0000 ^ a;
  endfunction

  assign inst_data = mem_word(inst_addr);

  pc_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_ce       (inst_ce),
    .inst_addr     (inst_addr),
    .inst_data     (inst_data),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_inst       (id_inst)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .id_adel       (id_adel)
`endif
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_full(input logic s, input logic f, input logic rv, input logic [31:0] rpc,
                          input logic [31:0] addr, input logic valid, input logic [31:0] pc,
                          input logic [31:0] inst, input logic adel);
    vec_t v;
    v.stall = s; v.flush = f; v.rv = rv; v.rpc = rpc; v.ce = 1'b1;
    v.addr = addr; v.valid = valid; v.pc = pc; v.inst = inst; v.adel = adel;
    vecs.push_back(v);
  endtask

  // Normal row: a valid entry holds the memory word at its PC, a bubble holds NOP.
  task automatic add(input logic s, input logic f, input logic rv, input logic [31:0] rpc,
                     input logic [31:0] addr, input logic valid, input logic [31:0] pc);
    add_full(s, f, rv, rpc, addr, valid, pc, valid ? mem_word(pc) : 32'h0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ce"}, inst_ce, 0);
    check({tag, "_addr"}, inst_addr, 32'h0);
    check({tag, "_valid"}, id_valid, 0);
    check({tag, "_pc"}, id_pc, 32'h0);
    check({tag, "_inst"}, id_inst, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    check({tag, "_adel"}, id_adel, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_reset_state("reset");
      $display("reset edge %0d: ce=%0b addr=%h valid=%0b", i, inst_ce, inst_addr, id_valid);
    end

    // First edge after release: ce rises, IF/ID still empty.
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0});
    add(0, 0, 0, 32'h0,  32'h4,  1, 32'h0);
    add(0, 0, 0, 32'h0,  32'h8,  1, 32'h4);
    add(1, 0, 0, 32'h0,  32'h8,  1, 32'h4);   // stall at pc=8
    add(1, 0, 0, 32'h0,  32'h8,  1, 32'h4);
    add(0, 0, 0, 32'h0,  32'hC,  1, 32'h8);
    add(0, 0, 0, 32'h0,  32'h10, 1, 32'hC);
    add(0, 0, 0, 32'h0,  32'h14, 1, 32'h10);
    add(0, 0, 0, 32'h0,  32'h18, 1, 32'h14);
    add(0, 0, 0, 32'h0,  32'h1C, 1, 32'h18);
    add(0, 0, 0, 32'h0,  32'h20, 1, 32'h1C);
    add(0, 0, 0, 32'h0,  32'h24, 1, 32'h20);
    add(0, 0, 1, 32'h50, 32'h50, 1, 32'h24);  // delay slot captured
    add(0, 0, 0, 32'h0,  32'h54, 1, 32'h50);
    add(0, 1, 1, 32'h70, 32'h70, 0, 32'h0);   // flush with redirect
    add(0, 0, 0, 32'h0,  32'h74, 1, 32'h70);
    add(1, 0, 1, 32'h80, 32'h74, 1, 32'h70);  // stall beats redirect
    add(0, 0, 1, 32'h80, 32'h80, 1, 32'h74);
    add(0, 0, 0, 32'h0,  32'h84, 1, 32'h80);
    add(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h84);
    add(0, 0, 0, 32'h0,  32'h0,  1, 32'hFFFF_FFFC);  // wrap
    add(0, 0, 0, 32'h0,  32'h4,  1, 32'h0);
    add(0, 1, 0, 32'h0,  32'h8,  0, 32'h0);   // flush alone, PC advances
    add(1, 1, 0, 32'h0,  32'h8,  0, 32'h0);   // flush beats stall, PC holds
`ifdef FETCH_ALIGN_CHECK_EN
    add(0, 0, 1, 32'h42, 32'h40, 1, 32'h8);
    add_full(0, 0, 0, 32'h0, 32'h44, 1, 32'h42, 32'h0, 1'b1);
    add(0, 0, 0, 32'h0,  32'h48, 1, 32'h44);
`else
    add(0, 0, 1, 32'h53, 32'h50, 1, 32'h8);   // low bits masked
    add(0, 0, 0, 32'h0,  32'h54, 1, 32'h50);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      stall          = vecs[i].stall;
      flush          = vecs[i].flush;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(posedge clk); #1;
      check($sformatf("v%0d_ce", i), inst_ce, vecs[i].ce);
      check($sformatf("v%0d_addr", i), inst_addr, vecs[i].addr);
      check($sformatf("v%0d_valid", i), id_valid, vecs[i].valid);
      check($sformatf("v%0d_pc", i), id_pc, vecs[i].pc);
      check($sformatf("v%0d_inst", i), id_inst, vecs[i].inst);
`ifdef FETCH_ALIGN_CHECK_EN
      check($sformatf("v%0d_adel", i), id_adel, vecs[i].adel);
`endif
      $display("vec %0d: s=%0b f=%0b rv=%0b rpc=%h -> addr=%h valid=%0b id_pc=%h id_inst=%h",
               i, vecs[i].stall, vecs[i].flush, vecs[i].rv, vecs[i].rpc,
               inst_addr, id_valid, id_pc, id_inst);
    end

    // Asynchronous reset mid-cycle, with a redirect pending that must be lost.
    @(negedge clk);
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h90;
    #1;
    check_reset_state("async_rst");
    $display("async reset: ce=%0b addr=%h valid=%0b", inst_ce, inst_addr, id_valid);
    @(posedge clk); #1;
    check_reset_state("rst_hold");
    @(negedge clk);
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("restart1_ce", inst_ce, 1);
    check("restart1_addr", inst_addr, 32'h0);
    check("restart1_valid", id_valid, 0);
    $display("restart edge 1: ce=%0b addr=%h valid=%0b", inst_ce, inst_addr, id_valid);
    @(posedge clk); #1;
    check("restart2_addr", inst_addr, 32'h4);
    check("restart2_valid", id_valid, 1);
    check("restart2_pc", id_pc, 32'h0);
    check("restart2_inst", id_inst, 32'h0000f025);
    $display("restart edge 2: addr=%h valid=%0b id_pc=%h id_inst=%h", inst_addr, id_valid, id_pc, id_inst);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage of the MIPS core. It owns the program counter and drives the instruction memory's chip-enable and byte address. It captures the returned instruction word, together with its PC, into the IF/ID pipeline register consumed by decode. It supports stall, flush and branch/jump redirect from downstream stages.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- NOP_INST, 32'h0000_0000, word inserted as a bubble.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- stall  input  1  hold the PC and the IF/ID register.
- flush  input  1  replace the IF/ID contents with a bubble.
- redirect_valid  input  1  load the PC from redirect_pc.
- redirect_pc  input  32  branch/jump target byte address.
- inst_ce  output  1  instruction memory chip-enable.
- inst_addr  output  32  instruction memory byte address; equals the PC.
- inst_data  input  32  instruction word, combinational from memory.
- id_valid  output  1  the IF/ID register holds a real instruction.
- id_pc  output  32  PC of the instruction in IF/ID.
- id_inst  output  32  instruction in IF/ID.
- id_adel  output  1  address-error flag; only present with FETCH_ALIGN_CHECK_EN.

## Operation
- Reset values:
  - pc = RESET_PC
  - inst_ce = 0
  - id_valid = 0
  - id_pc = 0
  - id_inst = NOP_INST
  - id_adel = 0
- inst_ce becomes 1 on the first edge after rst_n deasserts and stays 1 until the next reset.
- The PC updates only when inst_ce was 1. Priority, highest first:
  - stall: hold.
  - redirect_valid: pc ← {redirect_pc[31:2], 2'b00}.
  - otherwise: pc ← pc + 4. The addition is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0 with no flag.
- Redirect is ignored while stall=1. The redirect source must hold redirect_valid and redirect_pc until a cycle with stall=0.
- The IF/ID register updates on every edge. Priority, highest first:
  - flush: bubble (valid 0, inst NOP_INST, pc 0).
  - stall: hold.
  - inst_ce=0: bubble.
  - otherwise: capture {1, pc, inst_data}.
- Delay slot: the instruction being fetched in the cycle redirect_valid is accepted is the delay slot. It enters IF/ID normally unless flush is also asserted.
- flush does not affect the PC. A flush with redirect both clears IF/ID and loads the target.
- Reset asserted mid-operation immediately forces all reset values, asynchronously. Any in-flight redirect is lost.

## Timing
- inst_addr is a direct register output, so the memory address is valid early in each cycle. inst_data is sampled at the end of the same cycle.
- Fetch-to-decode latency is 1 cycle. The instruction at PC p appears on id_inst one edge after inst_addr = p.
- After reset release:
  - Edge 1: inst_ce=1, pc=RESET_PC.
  - Edge 2: id_valid=1 with id_pc=RESET_PC, and pc=RESET_PC+4.
- A redirect accepted at edge n puts the target on inst_addr after edge n. The target instruction reaches id_inst at edge n+1.
- Stall is fully combinational-to-hold with no lag. Throughput is one instruction per unstalled cycle.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect_pc with bits [1:0] ≠ 0 is loaded unaligned into an internal error flag alongside the masked PC.
  - The next IF/ID capture sets id_adel=1, forces id_inst=NOP_INST and keeps id_pc equal to the unaligned redirect_pc.
  - The flag clears when that bubble is captured.
- Undefined: the id_adel port is absent and the low two bits of redirect_pc are silently masked.

## Structure
- Shared package fetch_pkg holds:
  - INST_W = 32 and ADDR_W = 32
  - default RESET_PC and NOP_INST constants
  - a struct type if_id_t {valid, pc, inst, adel}
- One sub-module, if_id_reg, implements the IF/ID register with flush/stall priority. The PC logic and inst_ce sequencing stay in pc_fetch.

## Test plan
- Reset and startup:
  - Stimulus: hold rst_n=0 for 3 cycles with memory word 0 = 32'h0000f025 and word 1 = 32'h241d1000, then release.
  - Response: inst_ce=0 during reset; edge 2 gives id_pc=0, id_inst=32'h0000f025; edge 3 gives id_pc=4, id_inst=32'h241d1000.
- Stall:
  - Stimulus: assert stall for 2 cycles while pc=8.
  - Response: inst_addr holds 8 and id_* stay constant; after release, id_pc=8 appears on the next edge.
- Redirect with delay slot:
  - Stimulus: redirect_valid=1, redirect_pc=32'h50 while pc=32'h24.
  - Response: next id_pc=32'h24 (delay slot), then id_pc=32'h50.
- Flush plus redirect:
  - Stimulus: flush=1 and redirect_pc=32'h70 in the same cycle.
  - Response: id_valid=0, id_inst=0, then id_pc=32'h70.
- Stall beats redirect; wrap:
  - Stimulus: stall=1 with redirect_valid=1 to 32'h80, then stall=0. Separately, run from pc=32'hFFFF_FFFC.
  - Response: the PC loads 32'h80 only after stall drops; from 32'hFFFF_FFFC the next PC is 0.
- FETCH_ALIGN_CHECK_EN:
  - Stimulus: redirect_pc=32'h42.
  - Response: id_adel=1, id_inst=0, id_pc=32'h42; the following fetch proceeds from 32'h44.
